// File: rtl/vx_rr_onehot_arbiter.sv
// Round-robin arbiter with one-hot and binary grant outputs and an optional grant lock.
// Optional stall counter (perf_stalls) is built only when VX_ARB_PERF_EN is defined.
module vx_rr_onehot_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int LOCK_ENABLE  = 1,
    parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQS-1:0]     requests,
    input  logic                    grant_ready,
    output logic                    grant_valid,
    output logic [NUM_REQS-1:0]     grant_onehot,
    output logic [LOG_NUM_REQS-1:0] grant_index,
    output logic                    dbg_state_o,
    output logic [LOG_NUM_REQS-1:0] dbg_ptr_o
`ifdef VX_ARB_PERF_EN
    ,
    output logic [31:0]             perf_stalls
`endif
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    // Handshake: a grant fires on a cycle where grant_valid and grant_ready are both high.
    logic [0:0]              state_q, state_d;
    logic [NUM_REQS-1:0]     lock_onehot_q, lock_onehot_d;
    logic [LOG_NUM_REQS-1:0] lock_index_q, lock_index_d;
    logic [NUM_REQS-1:0]     rr_onehot;
    logic [LOG_NUM_REQS-1:0] rr_index;
    logic [LOG_NUM_REQS-1:0] ptr_w;
    logic                    locked;
    logic                    fire;

    assign locked       = (state_q == ST_LOCKED);
    assign grant_valid  = locked ? 1'b1 : (|requests);
    assign grant_onehot = locked ? lock_onehot_q : rr_onehot;
    assign grant_index  = locked ? lock_index_q : rr_index;
    assign fire         = grant_valid & grant_ready;
    assign dbg_state_o  = state_q[0];
    assign dbg_ptr_o    = ptr_w;

    generate
        if (NUM_REQS == 1) begin : g_single
            assign rr_onehot = requests;
            assign rr_index  = '0;
            assign ptr_w     = '0;
        end else begin : g_multi
            logic [LOG_NUM_REQS-1:0] ptr_q, ptr_d;
            logic                    found;
            int                      cand;

            // Scan upward from the pointer, wrapping, and take the first requester.
            always_comb begin
                rr_onehot = '0;
                rr_index  = '0;
                found     = 1'b0;
                cand      = 0;
                for (int i = 0; i < NUM_REQS; i++) begin
                    cand = int'(ptr_q) + i;
                    if (cand >= NUM_REQS) begin
                        cand = cand - NUM_REQS;
                    end
                    if (!found && requests[cand]) begin
                        found           = 1'b1;
                        rr_onehot[cand] = 1'b1;
                        rr_index        = cand[LOG_NUM_REQS-1:0];
                    end
                end
            end

            always_comb begin
                ptr_d = ptr_q;
                if (fire) begin
                    ptr_d = (grant_index == LOG_NUM_REQS'(NUM_REQS - 1)) ? '0 : grant_index + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end

            assign ptr_w = ptr_q;
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        lock_onehot_d = lock_onehot_q;
        lock_index_d  = lock_index_q;
        case (state_q)
            ST_UNLOCKED: begin
                if ((LOCK_ENABLE != 0) && grant_valid && !grant_ready) begin
                    state_d       = ST_LOCKED;
                    lock_onehot_d = rr_onehot;
                    lock_index_d  = rr_index;
                end
            end
            ST_LOCKED: begin
                if (grant_ready) begin
                    state_d = ST_UNLOCKED;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_UNLOCKED;
            lock_onehot_q <= '0;
            lock_index_q  <= '0;
        end else begin
            state_q       <= state_d;
            lock_onehot_q <= lock_onehot_d;
            lock_index_q  <= lock_index_d;
        end
    end

`ifdef VX_ARB_PERF_EN
    logic [31:0] perf_stalls_q;

    // Saturating count of cycles where a grant is presented but not taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stalls_q <= '0;
        end else if (grant_valid && !grant_ready && (perf_stalls_q != 32'hFFFF_FFFF)) begin
            perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_stalls = perf_stalls_q;
`endif

`ifndef SYNTHESIS
    // The held grant stays presented, but a requester dropping out before fire is a protocol slip.
    always @(posedge clk) begin
        if (reset_n && locked) begin
            assert ((requests & lock_onehot_q) != '0)
            else $warning("request withdrawn while grant locked");
        end
    end
`endif

endmodule

// File: tb/tb_vx_rr_onehot_arbiter.sv
// Directed bench for vx_rr_onehot_arbiter: a 4-requestor instance and a 1-requestor instance.
// Define VX_ARB_PERF_EN to also check the stall counter.
module tb_vx_rr_onehot_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] requests;
    logic       grant_ready;
    logic       grant_valid;
    logic [3:0] grant_onehot;
    logic [1:0] grant_index;
    logic       dbg_state;
    logic [1:0] dbg_ptr;
`ifdef VX_ARB_PERF_EN
    logic [31:0] perf_stalls;
    logic [31:0] perf_stalls1;
`endif

    logic [0:0] req1;
    logic       ready1;
    logic       valid1;
    logic [0:0] onehot1;
    logic [0:0] index1;
    logic       state1;
    logic [0:0] ptr1;

    int n_checks;
    int n_fail;

    vx_rr_onehot_arbiter #(.NUM_REQS(4), .LOCK_ENABLE(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .requests     (requests),
        .grant_ready  (grant_ready),
        .grant_valid  (grant_valid),
        .grant_onehot (grant_onehot),
        .grant_index  (grant_index),
        .dbg_state_o  (dbg_state),
        .dbg_ptr_o    (dbg_ptr)
`ifdef VX_ARB_PERF_EN
        ,
        .perf_stalls  (perf_stalls)
`endif
    );

    vx_rr_onehot_arbiter #(.NUM_REQS(1), .LOCK_ENABLE(1)) dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .requests     (req1),
        .grant_ready  (ready1),
        .grant_valid  (valid1),
        .grant_onehot (onehot1),
        .grant_index  (index1),
        .dbg_state_o  (state1),
        .dbg_ptr_o    (ptr1)
`ifdef VX_ARB_PERF_EN
        ,
        .perf_stalls  (perf_stalls1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        requests    = 4'b0000;
        grant_ready = 1'b0;
        req1        = 1'b0;
        ready1      = 1'b0;

        // Reset state and combinational follow-through while held in reset
        #2;
        check_eq("rst_valid", grant_valid, 0);
        check_eq("rst_onehot", grant_onehot, 0);
        check_eq("rst_index", grant_index, 0);
        check_eq("rst_state", dbg_state, 0);
        check_eq("rst_ptr", dbg_ptr, 0);
        requests = 4'b0100;
        #1;
        check_eq("rst_follow_oh", grant_onehot, 4'b0100);
        check_eq("rst_follow_idx", grant_index, 2);
        check_eq("rst_follow_valid", grant_valid, 1);
        requests = 4'b1010;
        #1;
        check_eq("rst_follow_oh2", grant_onehot, 4'b0010);
        check_eq("rst_follow_idx2", grant_index, 1);

        // Rotation with all requesting and always ready
        @(negedge clk);
        reset_n     = 1'b1;
        requests    = 4'b1111;
        grant_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq($sformatf("rot_idx%0d", k), grant_index, k % 4);
            check_eq($sformatf("rot_oh%0d", k), grant_onehot, 4'b0001 << (k % 4));
            @(posedge clk);
        end
        #1;
        check_eq("rot_ptr_end", dbg_ptr, 0);
        check_eq("rot_state", dbg_state, 0);

        // Skip idle requesters from pointer 1
        requests = 4'b0001;
        #1;
        check_eq("skip_pre_idx", grant_index, 0);
        step();
        check_eq("skip_ptr1", dbg_ptr, 1);
        requests = 4'b1001;
        #1;
        check_eq("skip_idx", grant_index, 3);
        check_eq("skip_oh", grant_onehot, 4'b1000);
        step();
        check_eq("skip_ptr_wrap", dbg_ptr, 0);
        check_eq("skip_next_idx", grant_index, 0);
        check_eq("skip_next_oh", grant_onehot, 4'b0001);

        // Lock held across three unready cycles while requests change
        requests    = 4'b0110;
        grant_ready = 1'b0;
        #1;
        check_eq("lock_pre_oh", grant_onehot, 4'b0010);
        check_eq("lock_pre_idx", grant_index, 1);
        step();
        check_eq("lock_state", dbg_state, 1);
        requests = 4'b0100;
        #1;
        check_eq("lock_hold_oh1", grant_onehot, 4'b0010);
        check_eq("lock_hold_valid1", grant_valid, 1);
        step();
        check_eq("lock_hold_oh2", grant_onehot, 4'b0010);
        check_eq("lock_hold_idx2", grant_index, 1);
        step();
        check_eq("lock_hold_oh3", grant_onehot, 4'b0010);
        check_eq("lock_hold_state3", dbg_state, 1);
        check_eq("lock_hold_ptr", dbg_ptr, 0);
        grant_ready = 1'b1;
        #1;
        check_eq("lock_fire_valid", grant_valid, 1);
        check_eq("lock_fire_oh", grant_onehot, 4'b0010);
        step();
        check_eq("unlock_state", dbg_state, 0);
        check_eq("unlock_ptr", dbg_ptr, 2);
        check_eq("unlock_idx", grant_index, 2);
        check_eq("unlock_oh", grant_onehot, 4'b0100);

        // Asynchronous reset while locked on index 2
        grant_ready = 1'b0;
        #1;
        step();
        check_eq("rml_state", dbg_state, 1);
        check_eq("rml_idx", grant_index, 2);
        check_eq("rml_ptr", dbg_ptr, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rml_async_state", dbg_state, 0);
        check_eq("rml_async_ptr", dbg_ptr, 0);
        requests = 4'b1111;
        #1;
        check_eq("rml_after_idx", grant_index, 0);
        check_eq("rml_after_oh", grant_onehot, 4'b0001);
        @(negedge clk);
        reset_n     = 1'b1;
        grant_ready = 1'b1;
        step();
        check_eq("rml_fire_ptr", dbg_ptr, 1);

        // Five stalled cycles, then acceptance
        #2;
        reset_n = 1'b0;
        #1;
        reset_n     = 1'b1;
        requests    = 4'b0001;
        grant_ready = 1'b0;
        repeat (5) step();
        check_eq("stall_state", dbg_state, 1);
        grant_ready = 1'b1;
        step();
        check_eq("stall_done_state", dbg_state, 0);
        check_eq("stall_done_ptr", dbg_ptr, 1);
`ifdef VX_ARB_PERF_EN
        check_eq("perf_stalls", perf_stalls, 5);
`endif

        // Single-requestor instance honours the lock
        req1   = 1'b1;
        ready1 = 1'b0;
        #1;
        check_eq("n1_valid", valid1, 1);
        check_eq("n1_oh", onehot1, 1);
        check_eq("n1_idx", index1, 0);
        step();
        check_eq("n1_locked", state1, 1);
        check_eq("n1_hold_oh", onehot1, 1);
        step();
        check_eq("n1_hold_valid", valid1, 1);
        ready1 = 1'b1;
        step();
        check_eq("n1_unlocked", state1, 0);
        req1 = 1'b0;
        #1;
        check_eq("n1_idle_valid", valid1, 0);
        check_eq("n1_idle_oh", onehot1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_rr_onehot_arbiter.md
VX_RR_ONEHOT_ARBITER -- requirements
Module: VX_rr_onehot_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of requestors, legal range 1..64.
REQ-002 SHALL have parameter LOCK_ENABLE, default 1: 1 = hold the grant until it is accepted, 0 = re-arbitrate every cycle.
REQ-003 SHALL have derived parameter LOG_NUM_REQS = max(1, ceil(log2(NUM_REQS))).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port requests, input, NUM_REQS bits: per-requestor request.
REQ-007 SHALL have port grant_valid, output, 1 bit: a grant is presented.
REQ-008 SHALL have port grant_onehot, output, NUM_REQS bits: one-hot grant that drives the select of the downstream one-hot mux.
REQ-009 SHALL have port grant_index, output, LOG_NUM_REQS bits: binary index of the granted requestor.
REQ-010 SHALL have port grant_ready, input, 1 bit: consumer accepts the grant.
REQ-011 SHALL have port perf_stalls, output, 32 bits: present only under VX_ARB_PERF_EN.

Function
REQ-012 grant_valid SHALL equal OR(requests), except while LOCKED (see REQ-017).
REQ-013 grant_onehot SHALL have at most one bit set, and SHALL be all-zero when grant_valid=0.
REQ-014 grant_index SHALL encode the set bit of grant_onehot, and SHALL be 0 when grant_valid=0.
REQ-015 Request to grant SHALL be combinational (zero latency); the priority pointer and lock state SHALL be registered.
REQ-016 Round-robin selection SHALL grant the first requesting index at or above the pointer, scanning upward and wrapping modulo NUM_REQS.
REQ-017 The FSM SHALL have two states, UNLOCKED and LOCKED, resetting to UNLOCKED.
REQ-018 UNLOCKED->LOCKED SHALL occur when LOCK_ENABLE=1, grant_valid=1 and grant_ready=0; the registered grant is captured at that edge.
REQ-019 In LOCKED, outputs SHALL present the captured grant with grant_valid=1, independent of the current requests.
REQ-020 LOCKED->UNLOCKED SHALL occur on the edge where grant_ready=1.
REQ-021 Fire is grant_valid and grant_ready; on fire the pointer SHALL load (grant_index+1) mod NUM_REQS, wrapping from NUM_REQS-1 to 0.
REQ-022 Without fire the pointer SHALL hold.
REQ-023 Requestors SHALL hold their request until fire; deassertion while LOCKED SHALL trigger a simulation-only assertion, and the grant SHALL still be held.
REQ-024 When NUM_REQS=1: grant_onehot = requests, grant_index = 0, no pointer state, and the lock is still honoured.
REQ-025 With all requests asserted and grant_ready=1 every cycle, grants SHALL rotate 0,1,...,N-1,0 with no index skipped.

Reset
REQ-026 Asserting reset_n=0 SHALL asynchronously clear the pointer to 0, the FSM to UNLOCKED, the captured grant to 0, and perf_stalls to 0.
REQ-027 During reset, outputs SHALL follow requests combinationally with the pointer at 0.
REQ-028 Reset while LOCKED SHALL drop the lock immediately.
REQ-029 Deassertion of reset_n SHALL be synchronised externally; the block SHALL act on the first rising edge after release.

Configuration
REQ-030 Macro VX_ARB_PERF_EN defined: perf_stalls SHALL increment by 1 on each cycle with grant_valid=1 and grant_ready=0.
REQ-031 perf_stalls SHALL saturate at 0xFFFFFFFF and not wrap.
REQ-032 Macro VX_ARB_PERF_EN undefined: the perf_stalls port and its counter SHALL not exist, and arbitration behaviour SHALL be identical.

Verification
REQ-033 Rotation: NUM_REQS=4, requests=4'b1111, grant_ready=1 for 8 cycles -> grant_index sequence 0,1,2,3,0,1,2,3, with grant_onehot matching.
REQ-034 Skip idle: pointer=1, requests=4'b1001 -> grant_index=3, onehot=4'b1000; after fire, pointer=0 and the next grant is index 0.
REQ-035 Lock: requests=4'b0110, grant_ready=0 for 3 cycles while requests change to 4'b0100 -> grant_onehot stays 4'b0010 and grant_valid=1; ready=1 -> fire, then UNLOCKED.
REQ-036 Reset mid-lock: LOCKED on index 2, then reset_n=0 asynchronously -> pointer=0 and state UNLOCKED before the next edge; requests=4'b1111 -> grant index 0.
REQ-037 Perf: VX_ARB_PERF_EN defined, one request held with grant_ready=0 for 5 cycles then 1 -> perf_stalls=5.
REQ-038 Perf without macro: with VX_ARB_PERF_EN undefined, the design compiles and the perf_stalls port is absent.
REQ-039 N=1: requests=1, grant_ready=0 then 1 -> grant_onehot=1, grant_index=0, with the grant held until ready.
